// File: rtl/ysyx_24070014_exec_ctrl_pkg.sv
// Shared definitions for the multi-cycle execution controller.
package ysyx_24070014_exec_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH      = 3'd0,
    ST_FETCH_RESP = 3'd1,
    ST_EXEC       = 3'd2,
    ST_MEM        = 3'd3,
    ST_MEM_RESP   = 3'd4,
    ST_COMMIT     = 3'd5,
    ST_HALT       = 3'd6
  } state_t;

  // addi x0,x0,0 -- what the decoder sees before the first fetch lands
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  // word accesses only: any set low address bit is an error
  function automatic logic word_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24070014_mem_req_reg.sv
// Memory request holder: keeps addr/wen/wdata frozen while a request
// waits for ready, so the bus never sees the fields move mid-handshake.
module ysyx_24070014_mem_req_reg #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic                req_wen,
  input  logic [DATA_LEN-1:0] req_wdata,
  input  logic                mem_req_ready,
  output logic                mem_req_valid,
  output logic [ADDR_LEN-1:0] mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_LEN-1:0] mem_req_wdata
);

  logic                hold;
  logic [ADDR_LEN-1:0] addr_q;
  logic                wen_q;
  logic [DATA_LEN-1:0] wdata_q;

  // capture fields on the first stalled cycle; hold while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      hold    <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      hold <= req_valid && !mem_req_ready;
      if (req_valid && !mem_req_ready && !hold) begin
        addr_q  <= req_addr;
        wen_q   <= req_wen;
        wdata_q <= req_wdata;
      end
    end
  end

  // first cycle of a request goes straight through; later cycles replay
  assign mem_req_valid = req_valid;
  assign mem_req_addr  = (hold && req_valid) ? addr_q  : req_addr;
  assign mem_req_wen   = (hold && req_valid) ? wen_q   : req_wen;
  assign mem_req_wdata = (hold && req_valid) ? wdata_q : req_wdata;

endmodule

// File: rtl/ysyx_24070014_exec_ctrl.sv
// Multi-cycle execution controller: fetch, latch, data access and commit
// gating over one shared handshaked memory port.
module ysyx_24070014_exec_ctrl
  import ysyx_24070014_exec_ctrl_pkg::*;
#(
  parameter int                  ADDR_LEN = 32,
  parameter int                  DATA_LEN = 32,
  parameter logic [ADDR_LEN-1:0] INIT_PC  = ADDR_LEN'(RESET_PC)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_LEN-1:0] core_pc,
  output logic [31:0]         inst,
  input  logic                dec_mem_read,
  input  logic                dec_mem_write,
  input  logic                dec_ebreak,
  input  logic [ADDR_LEN-1:0] core_mem_addr,
  input  logic [DATA_LEN-1:0] core_mem_wdata,
  output logic [DATA_LEN-1:0] core_mem_rdata,
  output logic                pc_update_en,
  output logic                reg_write_gate,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_LEN-1:0] mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_LEN-1:0] mem_req_wdata,
  input  logic                mem_resp_valid,
  input  logic [DATA_LEN-1:0] mem_resp_data,
  output logic                halted,
  output logic                err,
  output logic [63:0]         instret
);

  state_t              state;
  logic                req_valid;
  logic [ADDR_LEN-1:0] req_addr;
  logic                req_wen;
  logic                spurious_resp;
  logic                fetch_bad;
  logic                data_bad;

  assign fetch_bad = word_misaligned(core_pc[1:0]);
  assign data_bad  = word_misaligned(core_mem_addr[1:0]);

  // a response is only legal while a *_RESP state is waiting for it
  assign spurious_resp = mem_resp_valid &&
                         (state != ST_FETCH_RESP) && (state != ST_MEM_RESP);

  // request decode; misaligned accesses never reach the bus, and the
  // idle bus parks on the reset vector
  always_comb begin
    req_valid = 1'b0;
    req_addr  = INIT_PC;
    req_wen   = 1'b0;
    if (!reset) begin
      if (state == ST_FETCH) begin
        req_valid = !fetch_bad;
        req_addr  = core_pc;
      end else if (state == ST_MEM) begin
        req_valid = !data_bad;
        req_addr  = core_mem_addr;
        req_wen   = dec_mem_write;
      end
    end
  end

  ysyx_24070014_mem_req_reg #(
    .ADDR_LEN(ADDR_LEN),
    .DATA_LEN(DATA_LEN)
  ) u_req (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_wen      (req_wen),
    .req_wdata    (core_mem_wdata),
    .mem_req_ready(mem_req_ready),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr (mem_req_addr),
    .mem_req_wen  (mem_req_wen),
    .mem_req_wdata(mem_req_wdata)
  );

  // sequencer; commit strobes are registered so they line up with COMMIT
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_FETCH;
      inst           <= NOP_INST;
      core_mem_rdata <= '0;
      pc_update_en   <= 1'b0;
      reg_write_gate <= 1'b0;
      halted         <= 1'b0;
      err            <= 1'b0;
      instret        <= '0;
    end else begin
      pc_update_en   <= 1'b0;
      reg_write_gate <= 1'b0;
      if (spurious_resp) err <= 1'b1;
      case (state)
        ST_FETCH: begin
          if (spurious_resp || fetch_bad) begin
            err    <= 1'b1;
            halted <= 1'b1;
            state  <= ST_HALT;
          end else if (mem_req_ready) begin
            state <= ST_FETCH_RESP;
          end
        end
        ST_FETCH_RESP: begin
          if (mem_resp_valid) begin
            inst  <= mem_resp_data[31:0];
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (spurious_resp) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else if (dec_ebreak) begin
            // ebreak retires but leaves the PC where it is
            instret <= instret + 64'd1;
            halted  <= 1'b1;
            state   <= ST_HALT;
          end else if (dec_mem_read || dec_mem_write) begin
            state <= ST_MEM;
          end else begin
            pc_update_en   <= 1'b1;
            reg_write_gate <= 1'b1;
            state          <= ST_COMMIT;
          end
        end
        ST_MEM: begin
          if (spurious_resp || data_bad) begin
            err    <= 1'b1;
            halted <= 1'b1;
            state  <= ST_HALT;
          end else if (mem_req_ready) begin
            state <= ST_MEM_RESP;
          end
        end
        ST_MEM_RESP: begin
          // stores also wait here for their write acknowledge
          if (mem_resp_valid) begin
            if (dec_mem_read) core_mem_rdata <= mem_resp_data;
            pc_update_en   <= 1'b1;
            reg_write_gate <= 1'b1;
            state          <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          instret <= instret + 64'd1;
          if (spurious_resp) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_HALT: ;
        default: begin
          halted <= 1'b1;
          state  <= ST_HALT;
        end
      endcase
    end
  end

endmodule
